// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - PC/register-write run monitor with halt/timeout detection and trace ring
module cpu_run_monitor #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4,
    parameter int MAX_CYCLES  = 4096,
    parameter int CNT_WIDTH   = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Clear,
    input  logic [DATA_WIDTH-1:0]   PCIn,
    input  logic                    WriteValid,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [AW-1:0]           TraceAddr,
    output logic [2*DATA_WIDTH-1:0] TraceData,
    output logic [AW:0]             TraceCount,
    output logic [CNT_WIDTH-1:0]    CycleCount,
    output logic [CNT_WIDTH-1:0]    InstrCount,
    output logic [DATA_WIDTH-1:0]   Signature,
    output logic                    Halted,
    output logic                    Timeout
);

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_TIMEOUT} state_t;

    localparam int SW = $clog2(HALT_CYCLES) + 1;
    // A PC value seen in HALT_CYCLES consecutive samples gives HALT_CYCLES-1 matches.
    localparam logic [SW-1:0] HALT_MATCH = SW'(HALT_CYCLES - 2);
    localparam logic [31:0]   CYC_LAST   = 32'(MAX_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_SLOT  = AW'(DEPTH - 1);

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   pc_prev;
    logic [SW-1:0]           stable_cnt;
    logic [AW-1:0]           wptr;
    logic                    wrapped;
    logic [2*DATA_WIDTH-1:0] mem [DEPTH];

    logic                    running;
    logic                    pc_match;
    logic                    halt_hit;
    logic                    timeout_hit;
    logic                    mem_we;
    logic [AW-1:0]           oldest;
    logic [AW-1:0]           rd_idx;
    logic [2*DATA_WIDTH-1:0] trace_rd;

    assign running     = (state == S_RUN);
    assign pc_match    = (PCIn == pc_prev);
    assign halt_hit    = running && pc_match && (stable_cnt >= HALT_MATCH);
    assign timeout_hit = running && (32'(CycleCount) >= CYC_LAST);
    assign mem_we      = running && WriteValid && !Clear;

    assign oldest   = wrapped ? wptr : '0;
    assign rd_idx   = oldest + TraceAddr;
    assign trace_rd = ({1'b0, TraceAddr} < TraceCount) ? mem[rd_idx] : '0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= S_RUN;
        else if (Clear)
            state <= S_RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (halt_hit)
                    state_next = S_HALTED;
                else if (timeout_hit)
                    state_next = S_TIMEOUT;
            end
            S_HALTED:  state_next = S_HALTED;
            S_TIMEOUT: state_next = S_TIMEOUT;
            default:   state_next = S_RUN;
        endcase
    end

    always_comb begin
        Halted  = 1'b0;
        Timeout = 1'b0;
        case (state)
            S_HALTED:  Halted  = 1'b1;
            S_TIMEOUT: Timeout = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_prev    <= '0;
            stable_cnt <= '0;
            CycleCount <= '0;
            InstrCount <= '0;
            Signature  <= '0;
            wptr       <= '0;
            wrapped    <= 1'b0;
            TraceCount <= '0;
            TraceData  <= '0;
        end else if (Clear) begin
            pc_prev    <= '0;
            stable_cnt <= '0;
            CycleCount <= '0;
            InstrCount <= '0;
            Signature  <= '0;
            wptr       <= '0;
            wrapped    <= 1'b0;
            TraceCount <= '0;
            TraceData  <= '0;
        end else begin
            TraceData <= trace_rd;
            if (running) begin
                // The timeout edge holds CycleCount one short of the budget.
                if (!timeout_hit && !(&CycleCount))
                    CycleCount <= CycleCount + 1'b1;
                pc_prev <= PCIn;
                if (pc_match) begin
                    if (!(&stable_cnt))
                        stable_cnt <= stable_cnt + 1'b1;
                end else begin
                    stable_cnt <= '0;
                    if (!(&InstrCount))
                        InstrCount <= InstrCount + 1'b1;
                end
                if (WriteValid) begin
                    Signature <= {Signature[DATA_WIDTH-2:0], Signature[DATA_WIDTH-1]} ^ WriteData;
                    wptr      <= wptr + 1'b1;
                    if (wptr == LAST_SLOT)
                        wrapped <= 1'b1;
                    if (TraceCount != FULL_CNT)
                        TraceCount <= TraceCount + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we)
            mem[wptr] <= {PCIn, WriteData};
    end

endmodule
